// File: rtl/plab2_proc_fetch_drop_queue.sv
// plab2_proc_fetch_drop_queue
//   Combined imem request bypass queue and squash drop unit for the fetch stage.
//   Counts outstanding imem requests. On a squash, every response still in flight
//   is marked stale and discarded as it returns.
//   Optional feature macro: PLAB2_PROC_FETCH_DROP_STATS_EN builds a saturating
//   32-bit counter of discarded responses on drop_count. Without the macro,
//   drop_count is tied to zero.
//   All message data belongs to the security domain given by 'domain'. The
//   control and handshake signals are public.
module plab2_proc_fetch_drop_queue #(
  parameter int p_req_nbits    = 77,
  parameter int p_resp_nbits   = 47,
  parameter int p_max_inflight = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  input  logic                    squash,
  input  logic [p_req_nbits-1:0]  req_in_msg,
  input  logic                    req_in_val,
  output logic                    req_in_rdy,
  output logic [p_req_nbits-1:0]  req_out_msg,
  output logic                    req_out_val,
  input  logic                    req_out_rdy,
  input  logic [p_resp_nbits-1:0] resp_in_msg,
  input  logic                    resp_in_val,
  output logic                    resp_in_rdy,
  output logic [p_resp_nbits-1:0] resp_out_msg,
  output logic                    resp_out_val,
  input  logic                    resp_out_rdy,
  output logic [31:0]             drop_count
);

  localparam int c = $clog2(p_max_inflight + 1);
  localparam logic [c-1:0] max_inflight = p_max_inflight[c-1:0];

  logic [c-1:0] inflight;
  logic [c-1:0] drop_cnt;
  logic [c-1:0] inflight_next;
  logic [c-1:0] drop_cnt_next;
  logic         full;
  logic         have_inflight;
  logic         drop_mode;
  logic         req_fire;
  logic         resp_fire;

  // The security label only tags the data. No logic depends on it.
  logic unused_domain;
  assign unused_domain = domain;

  // Request path: zero-latency passthrough, blocked while the window is full
  always_comb begin
    full        = (inflight == max_inflight);
    req_out_msg = req_in_msg;
    req_out_val = req_in_val & ~full;
    req_in_rdy  = req_out_rdy & ~full;
    req_fire    = req_out_val & req_out_rdy;
  end

  // Response path: drop stale responses, otherwise pass through. During a squash,
  // a response is consumed but never shown to decode.
  always_comb begin
    have_inflight = (inflight != '0);
    drop_mode     = (drop_cnt != '0);
    resp_out_msg  = resp_in_msg;
    resp_out_val  = 1'b0;
    resp_in_rdy   = have_inflight;
    if (!drop_mode) begin
      resp_out_val = resp_in_val & ~squash & have_inflight;
      resp_in_rdy  = have_inflight & (resp_out_rdy | squash);
    end
    resp_fire = resp_in_val & resp_in_rdy;
  end

  // Counter next-state. A squash makes everything outstanding stale, including a
  // request issued in the same cycle.
  always_comb begin
    inflight_next = inflight + c'(req_fire) - c'(resp_fire);
    drop_cnt_next = drop_cnt;
    if (squash)
      drop_cnt_next = inflight_next;
    else if (drop_mode && resp_fire)
      drop_cnt_next = drop_cnt - 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      drop_cnt <= drop_cnt_next;
    end
  end

`ifdef PLAB2_PROC_FETCH_DROP_STATS_EN
  logic discard;
  assign discard = resp_fire & (drop_mode | squash);

  // Saturating count of discarded responses
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= 32'd0;
    else if (discard && (drop_count != 32'hFFFF_FFFF))
      drop_count <= drop_count + 32'd1;
  end
`else
  assign drop_count = 32'd0;
`endif

endmodule
